irq_ctrl: RTL and testbench

- Machine-mode interrupt controller between the CLINT and the core's trap logic.
- Masks, prioritises and latches pending interrupts (external, software, timer), then raises a single request to the core with its mcause code.
- Sequences the handshake: trap acknowledge, then a one-cycle clear pulse back to the source, then wait for mret.
- Enforces a hold-off gap before the next request, so a level that is still stale in the CLINT is not re-taken.

---
 rtl/irq_ctrl.sv | 82 ++++++++
 tb/tb_irq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt prioritiser and trap handshake sequencer
module irq_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_external,
  input  logic irq_software,
  input  logic irq_timer,
  input  logic mstatus_mie,
  input  logic mie_meie,
  input  logic mie_msie,
  input  logic mie_mtie,
  input  logic debug_mode,
  input  logic int_ack,
  input  logic mret,
  output logic int_req,
  output logic [WORD_WIDTH-1:0] int_cause,
  output logic software_int_clear,
  output logic timer_int_clear,
  output logic ext_int_claim,
  output logic mip_meip,
  output logic mip_msip,
  output logic mip_mtip,
  output logic busy
);
  localparam int CW = HOLDOFF > 1 ? $clog2(HOLDOFF + 1) : 1;
  typedef enum logic [2:0] {IDLE, REQ, CLEAR, HANDLER, HOLD} state_t;
  state_t state, state_nx;
  logic [2:0] elig, src, src_nx;
  logic [3:0] code, code_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] mip;
  // one-hot source order {timer, software, external}; code 0 only after reset
  assign elig = {irq_timer & mie_mtie, irq_software & mie_msie, irq_external & mie_meie}
              & {3{mstatus_mie & ~debug_mode}};
  always_comb begin
    state_nx = state;
    src_nx = src;
    code_nx = code;
    cnt_nx = cnt;
    case (state)
      IDLE: if (|elig) begin
        state_nx = REQ;
        src_nx = elig[0] ? 3'b001 : elig[1] ? 3'b010 : 3'b100;
        code_nx = elig[0] ? 4'd11 : elig[1] ? 4'd3 : 4'd7;
      end
      REQ: state_nx = int_ack ? CLEAR : |(elig & src) ? REQ : IDLE;
      CLEAR: state_nx = HANDLER;
      HANDLER: if (mret) begin
        state_nx = HOLDOFF == 0 ? IDLE : HOLD;
        cnt_nx = CW'(HOLDOFF);
      end
      HOLD: begin
        cnt_nx = cnt <= CW'(1) ? '0 : cnt - 1'b1;
        state_nx = cnt <= CW'(1) ? IDLE : HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= '0;
      code <= '0;
      cnt <= '0;
      mip <= '0;
    end else begin
      state <= state_nx;
      src <= src_nx;
      code <= code_nx;
      cnt <= cnt_nx;
      mip <= {irq_timer, irq_software, irq_external};
    end
  end
  assign int_req = state == REQ;
  assign int_cause = code == 4'd0 ? '0 : {1'b1, {(WORD_WIDTH-5){1'b0}}, code};
  assign {timer_int_clear, software_int_clear, ext_int_claim} = state == CLEAR ? src : 3'b000;
  assign {mip_mtip, mip_msip, mip_meip} = mip;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl, HOLDOFF=2 and HOLDOFF=0 instances side by side
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic rst, irq_external, irq_software, irq_timer, mstatus_mie;
  logic mie_meie, mie_msie, mie_mtie, debug_mode, int_ack, mret;
  typedef struct packed {
    logic req;
    logic [31:0] cause;
    logic sclr, tclr, eclm, meip, msip, mtip, busy;
  } obs_t;
  obs_t q0[$], q1[$];
  int errors = 0, checks = 0;
  logic r0, s0, t0, e0, pe0, ps0, pt0, b0;
  logic r1, s1, t1, e1, pe1, ps1, pt1, b1;
  logic [31:0] c0, c1;

  always #5 clk = ~clk;

  irq_ctrl #(.WORD_WIDTH(32), .HOLDOFF(2)) u0 (
    .clk(clk), .rst(rst), .irq_external(irq_external), .irq_software(irq_software),
    .irq_timer(irq_timer), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_msie(mie_msie), .mie_mtie(mie_mtie), .debug_mode(debug_mode),
    .int_ack(int_ack), .mret(mret), .int_req(r0), .int_cause(c0),
    .software_int_clear(s0), .timer_int_clear(t0), .ext_int_claim(e0),
    .mip_meip(pe0), .mip_msip(ps0), .mip_mtip(pt0), .busy(b0));

  irq_ctrl #(.WORD_WIDTH(32), .HOLDOFF(0)) u1 (
    .clk(clk), .rst(rst), .irq_external(irq_external), .irq_software(irq_software),
    .irq_timer(irq_timer), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_msie(mie_msie), .mie_mtie(mie_mtie), .debug_mode(debug_mode),
    .int_ack(int_ack), .mret(mret), .int_req(r1), .int_cause(c1),
    .software_int_clear(s1), .timer_int_clear(t1), .ext_int_claim(e1),
    .mip_meip(pe1), .mip_msip(ps1), .mip_mtip(pt1), .busy(b1));

  // Reference: the trap lifecycle as a few flags plus a hold-off countdown.
  int holdoff[2] = '{2, 0};
  bit requesting[2], clearing[2], in_handler[2];
  int hold_left[2], served[2];
  logic [31:0] cause_m[2];

  function automatic bit eligible(int s);
    bit lvl, en;
    lvl = s == 0 ? irq_external : s == 1 ? irq_software : irq_timer;
    en = s == 0 ? mie_meie : s == 1 ? mie_msie : mie_mtie;
    return lvl && en && mstatus_mie && !debug_mode;
  endfunction

  task automatic model_step(input int k, output obs_t o);
    if (rst) begin
      requesting[k] = 0;
      clearing[k] = 0;
      in_handler[k] = 0;
      hold_left[k] = 0;
      cause_m[k] = 0;
    end else if (requesting[k]) begin
      requesting[k] = 0;
      if (int_ack) clearing[k] = 1;
      else if (eligible(served[k])) requesting[k] = 1;
    end else if (clearing[k]) begin
      clearing[k] = 0;
      in_handler[k] = 1;
    end else if (in_handler[k]) begin
      if (mret) begin
        in_handler[k] = 0;
        hold_left[k] = holdoff[k];
      end
    end else if (hold_left[k] > 0) begin
      hold_left[k] = hold_left[k] - 1;
    end else begin
      for (int s = 0; s < 3; s++)
        if (eligible(s)) begin
          requesting[k] = 1;
          served[k] = s;
          cause_m[k] = 32'h8000_0000 + (s == 0 ? 11 : s == 1 ? 3 : 7);
          break;
        end
    end
    o.req = requesting[k];
    o.cause = cause_m[k];
    o.sclr = clearing[k] && served[k] == 1;
    o.tclr = clearing[k] && served[k] == 2;
    o.eclm = clearing[k] && served[k] == 0;
    o.meip = !rst && irq_external;
    o.msip = !rst && irq_software;
    o.mtip = !rst && irq_timer;
    o.busy = requesting[k] || clearing[k] || in_handler[k] || hold_left[k] > 0;
  endtask

  task automatic tick();
    obs_t e;
    model_step(0, e);
    q0.push_back(e);
    model_step(1, e);
    q1.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_ack();
    int_ack = 1;
    tick();
    int_ack = 0;
  endtask

  task automatic pulse_mret();
    mret = 1;
    tick();
    mret = 0;
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {r0, c0, s0, t0, e0, pe0, ps0, pt0, b0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL holdoff2 t=%0t got req=%b cause=%h clr(s,t,e)=%b%b%b mip=%b%b%b busy=%b want req=%b cause=%h clr=%b%b%b mip=%b%b%b busy=%b",
          $time, a.req, a.cause, a.sclr, a.tclr, a.eclm, a.meip, a.msip, a.mtip, a.busy,
          e.req, e.cause, e.sclr, e.tclr, e.eclm, e.meip, e.msip, e.mtip, e.busy);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {r1, c1, s1, t1, e1, pe1, ps1, pt1, b1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL holdoff0 t=%0t got req=%b cause=%h clr(s,t,e)=%b%b%b mip=%b%b%b busy=%b want req=%b cause=%h clr=%b%b%b mip=%b%b%b busy=%b",
          $time, a.req, a.cause, a.sclr, a.tclr, a.eclm, a.meip, a.msip, a.mtip, a.busy,
          e.req, e.cause, e.sclr, e.tclr, e.eclm, e.meip, e.msip, e.mtip, e.busy);
      end
    end
  end

  initial begin
    {irq_external, irq_software, irq_timer, mstatus_mie} = '0;
    {mie_meie, mie_msie, mie_mtie, debug_mode, int_ack, mret} = '0;
    rst = 1;
    run(3);
    rst = 0;
    run(2);
    // timer only
    mstatus_mie = 1;
    mie_mtie = 1;
    irq_timer = 1;
    run(3);
    pulse_ack();
    irq_timer = 0;
    run(4);
    pulse_mret();
    run(4);
    // priority: all three together, the served one drops after its clear
    {mie_meie, mie_msie} = 2'b11;
    {irq_external, irq_software, irq_timer} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      run(2);
      pulse_ack();
      if (irq_external) irq_external = 0;
      else if (irq_software) irq_software = 0;
      else irq_timer = 0;
      run(3);
      pulse_mret();
      run(4);
    end
    // withdrawal, then ack racing the withdrawal
    irq_software = 1;
    run(2);
    mstatus_mie = 0;
    run(2);
    mstatus_mie = 1;
    run(2);
    mstatus_mie = 0;
    pulse_ack();
    irq_software = 0;
    mstatus_mie = 1;
    run(3);
    pulse_mret();
    run(4);
    // masking by debug, then by per-source enable
    debug_mode = 1;
    irq_timer = 1;
    run(4);
    debug_mode = 0;
    mie_mtie = 0;
    run(4);
    // reset while in CLEAR with the timer still eligible
    mie_mtie = 1;
    run(2);
    pulse_ack();
    rst = 1;
    tick();
    rst = 0;
    run(3);
    pulse_ack();
    run(2);
    irq_timer = 1;
    pulse_mret();
    run(5);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) < 10) irq_external = ~irq_external;
      if ($urandom_range(99) < 10) irq_software = ~irq_software;
      if ($urandom_range(99) < 10) irq_timer = ~irq_timer;
      mstatus_mie = $urandom_range(99) < 93;
      mie_meie = $urandom_range(99) < 85;
      mie_msie = $urandom_range(99) < 85;
      mie_mtie = $urandom_range(99) < 85;
      debug_mode = $urandom_range(99) < 4;
      int_ack = $urandom_range(99) < 30;
      mret = $urandom_range(99) < 15;
      rst = $urandom_range(999) < 8;
      tick();
    end
    {int_ack, mret, rst} = '0;
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d leftover want 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
